apb_req_master: RTL and testbench

// - Upstream driver for an APB4 (v2.0) master port: converts a valid/ready request stream
//   (addr/write/wdata/strb) into one APB4 SETUP+ACCESS transfer at a time.
// - Returns a valid/ready response (rdata/err) for every accepted request.
// - Sits between a core-side/bus-side request source and the APB Master modport.
// - A wait-state timeout guards against slaves that never raise pready.

---
 rtl/apb_req_master_pkg.sv | 18 +
 rtl/apb_req_master.sv | 113 +++++++++++
 tb/tb_apb_req_master.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/apb_req_master_pkg.sv
// Shared definitions for the APB request master: FSM state encoding and sizing helpers.
package apb_req_master_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Timeout counter holds 0..TIMEOUT_CYCLES; at least one bit even when disabled.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/apb_req_master.sv
// Converts a valid/ready request stream into single APB4 SETUP+ACCESS transfers
// and returns one valid/ready response per accepted request.
module apb_req_master
  import apb_req_master_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int STRB_WIDTH    = ceil_div(DATA_WIDTH, 8)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic                  req_write_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [STRB_WIDTH-1:0] req_strb_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic                  pwrite_o,
  output logic [DATA_WIDTH-1:0] pwdata_o,
  output logic [STRB_WIDTH-1:0] pstrb_o,
  output logic                  psel_o,
  output logic                  penable_o,
  input  logic                  pready_i,
  input  logic [DATA_WIDTH-1:0] prdata_i,
  input  logic                  pslverr_i
);

  localparam int               CNT_W   = cnt_width(TIMEOUT_CYCLES);
  localparam bit               TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TO_EN ? TIMEOUT_CYCLES : 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

  logic [1:0]            state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] strb_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  timeout_hit;

  // The count reaches TIMEOUT_CYCLES on the edge that leaves ACCESS, so the
  // last permitted wait cycle is the one where the count still reads TIMEOUT_CYCLES-1.
  assign timeout_hit = TO_EN && (cnt_q == TO_LAST);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            addr_q  <= req_addr_i;
            write_q <= req_write_i;
            wdata_q <= req_wdata_i;
            strb_q  <= req_strb_i;
            state_q <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          cnt_q   <= '0;
          state_q <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (pready_i) begin
            // Slave response takes priority over a coincident timeout.
            rdata_q <= (!write_q && !pslverr_i) ? prdata_i : '0;
            err_q   <= pslverr_i;
            state_q <= ST_RESP;
          end else begin
            if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
            if (timeout_hit) begin
              rdata_q <= '0;
              err_q   <= 1'b1;
              state_q <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o = rst_ni && (state_q == ST_IDLE);
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

  assign psel_o    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign penable_o = (state_q == ST_ACCESS);
  assign paddr_o   = addr_q;
  assign pwrite_o  = write_q;
  assign pwdata_o  = wdata_q;
  assign pstrb_o   = write_q ? strb_q : '0;

endmodule

// File: tb/tb_apb_req_master.sv
// Directed bench for apb_req_master: drives requests and a scripted APB slave, checks every phase.
module tb_apb_req_master;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic        req_write_i;
  logic [31:0] req_wdata_i;
  logic [3:0]  req_strb_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic [31:0] paddr_o;
  logic        pwrite_o;
  logic [31:0] pwdata_o;
  logic [3:0]  pstrb_o;
  logic        psel_o;
  logic        penable_o;
  logic        pready_i;
  logic [31:0] prdata_i;
  logic        pslverr_i;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  apb_req_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_write_i(req_write_i),
    .req_wdata_i(req_wdata_i), .req_strb_i(req_strb_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .paddr_o(paddr_o), .pwrite_o(pwrite_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
    .psel_o(psel_o), .penable_o(penable_o),
    .pready_i(pready_i), .prdata_i(prdata_i), .pslverr_i(pslverr_i)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One transfer: ws = slave wait states before pready (large = never), hold = cycles
  // rsp_ready stays low, pend = present a follow-up request (addr a+4) during the stall.
  // Called and returns just after a negedge.
  task automatic xfer(input string nm, input logic [31:0] a, input logic w,
                      input logic [31:0] d, input logic [3:0] s, input int ws,
                      input logic se, input logic [31:0] rd, input int hold, input bit pend,
                      input int exp_pen, input logic exp_err, input logic [31:0] exp_rdata);
    int pen;
    bit stable;
    logic [31:0] rd_seen;
    req_addr_i  = a; req_write_i = w; req_wdata_i = d; req_strb_i = s;
    req_valid_i = 1'b1;
    rsp_ready_i = (hold == 0);
    chk({nm, ".req_ready"}, req_ready_o, 1);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    chk({nm, ".setup"}, {psel_o, penable_o, pwrite_o}, {2'b10, w});
    chk({nm, ".paddr"}, paddr_o, a);
    chk({nm, ".pstrb"}, pstrb_o, w ? s : 4'h0);
    if (w) chk({nm, ".pwdata"}, pwdata_o, d);
    pen = 0; stable = 1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk_i);
      if (!penable_o) break;
      pen++;
      stable &= psel_o && (paddr_o == a) && (pwdata_o == d) && (pwrite_o == w);
      pready_i  = (pen == ws + 1);
      prdata_i  = rd;
      pslverr_i = se;
    end
    pready_i = 1'b0; pslverr_i = 1'b0; prdata_i = 32'h5A5A_5A5A;
    chk({nm, ".stable"}, stable, 1);
    chk({nm, ".pen_cycles"}, pen, exp_pen);
    chk({nm, ".rsp"}, {rsp_valid_o, psel_o, rsp_err_o}, {2'b10, exp_err});
    chk({nm, ".rdata"}, rsp_rdata_o, exp_rdata);
    if (hold > 0) begin
      if (pend) begin
        req_addr_i = a + 32'h4; req_valid_i = 1'b1;
      end
      rd_seen = rsp_rdata_o;
      stable = 1;
      for (int c = 0; c < hold; c++) begin
        @(negedge clk_i);
        stable &= rsp_valid_o && !req_ready_o && !psel_o &&
                  (rsp_rdata_o == rd_seen) && (rsp_err_o == exp_err);
      end
      chk({nm, ".stall"}, stable, 1);
      rsp_ready_i = 1'b1;
    end
    @(negedge clk_i);
    chk({nm, ".done"}, {rsp_valid_o, req_ready_o, psel_o}, 3'b010);
  endtask

  initial begin
    bit ok;
    rst_ni = 1'b0; req_valid_i = 1'b0; req_addr_i = '0; req_write_i = 1'b0;
    req_wdata_i = '0; req_strb_i = '0; rsp_ready_i = 1'b1;
    pready_i = 1'b0; prdata_i = '0; pslverr_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("rst.ctrl", {req_ready_o, rsp_valid_o, psel_o, penable_o, rsp_err_o}, 5'b0);
    chk("rst.data", {paddr_o, pwdata_o}, 64'h0);
    chk("rst.strb", {pstrb_o, pwrite_o, rsp_rdata_o}, 37'h0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("rst.ready", req_ready_o, 1);

    xfer("wr",  32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h1111_2222, 0, 0, 1, 1'b0, 32'h0);
    xfer("rd3", 32'h24, 1'b0, 32'h0, 4'hF, 3, 1'b0, 32'hCAFE0001, 0, 0, 4, 1'b0, 32'hCAFE0001);
    xfer("slv", 32'h30, 1'b0, 32'h0, 4'h0, 1, 1'b1, 32'h7777_7777, 0, 0, 2, 1'b1, 32'h0);
    xfer("wrs", 32'h34, 1'b1, 32'h0BAD_F00D, 4'h5, 2, 1'b0, 32'h0, 0, 0, 3, 1'b0, 32'h0);
    xfer("to",  32'h40, 1'b0, 32'h0, 4'h0, 1000, 1'b0, 32'h9999_9999, 0, 0, 16, 1'b1, 32'h0);
    xfer("to15", 32'h44, 1'b0, 32'h0, 4'h0, 15, 1'b0, 32'h1234_5678, 0, 0, 16, 1'b0, 32'h1234_5678);
    xfer("to14", 32'h48, 1'b0, 32'h0, 4'h0, 14, 1'b1, 32'h1234_5678, 0, 0, 15, 1'b1, 32'h0);

    xfer("bp",  32'h50, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'hABCD_0050, 5, 1, 1, 1'b0, 32'hABCD_0050);
    xfer("bp2", 32'h54, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'hABCD_0054, 0, 0, 1, 1'b0, 32'hABCD_0054);

    req_addr_i = 32'h60; req_write_i = 1'b1; req_wdata_i = 32'hFFFF_0000; req_strb_i = 4'h3;
    req_valid_i = 1'b1;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    @(negedge clk_i);
    chk("arst.access", {psel_o, penable_o}, 2'b11);
    pready_i = 1'b0;
    rst_ni = 1'b0;
    chk("arst.ready_low", req_ready_o, 0);
    @(negedge clk_i);
    chk("arst.abandon", {psel_o, penable_o, rsp_valid_o, pstrb_o}, 7'b0);
    rst_ni = 1'b1;
    ok = 1;
    repeat (3) begin
      @(negedge clk_i);
      ok &= !rsp_valid_o && !psel_o;
    end
    chk("arst.no_rsp", ok, 1);
    xfer("post", 32'h70, 1'b0, 32'h0, 4'h0, 1, 1'b0, 32'h0F0F_7070, 0, 0, 2, 1'b0, 32'h0F0F_7070);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
